// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: the EX-stage interface between the pipeline and the multiply/divide unit.
//   master modport (pipeline side):
//     drives    ex_valid, opcode_ex, func_ex, rs_val, rt_val
//     receives  stall_req, busy, hi, lo, mf_data
//   slave modport (ex_muldiv side): the same signals with the directions reversed.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             ex_valid;
  logic [5:0]       opcode_ex;
  logic [5:0]       func_ex;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             stall_req;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;

  modport master (
    output ex_valid, opcode_ex, func_ex, rs_val, rt_val,
    input  stall_req, busy, hi, lo, mf_data
  );

  modport slave (
    input  ex_valid, opcode_ex, func_ex, rs_val, rt_val,
    output stall_req, busy, hi, lo, mf_data
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU run for WIDTH cycles in the background. MFHI/MFLO/MTHI/MTLO access
// HI/LO directly. A stall is requested when an HI/LO-dependent instruction reaches EX
// while an operation is still in flight.
// Ports:
//   clk  - pipeline clock; all state updates happen on the rising edge
//   rst  - synchronous, active-high reset; aborts any in-flight operation
//   bus  - ex_muldiv_if.slave:
//          ex_valid/opcode_ex/func_ex/rs_val/rt_val are the decoded EX instruction;
//          stall_req holds IF/ID/EX; busy is high while an op runs;
//          hi/lo are the HI/LO registers; mf_data is the MFHI/MFLO result.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic               is_mul_reg;
  logic               res_neg_reg;
  logic               rem_neg_reg;
  logic               dz_reg;
  // Multiplicand for MUL, divisor for DIV (both as magnitudes).
  logic [WIDTH-1:0]   opb_reg;
  // MUL: {partial product high, multiplier shifting out}.
  // DIV: {remainder, quotient/dividend shifting}.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  // Decode
  logic is_r, is_start, is_hilo, is_mthi, is_mtlo, is_mfhi, is_mflo;
  logic accept, busy_w, stall_w;
  logic start_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign is_r     = (bus.opcode_ex == 6'h00);
  assign is_start = is_r && (bus.func_ex[5:2] == 4'b0110);   // 18..1B
  assign is_hilo  = is_r && (bus.func_ex[5:2] == 4'b0100);   // 10..13
  assign is_mfhi  = is_r && (bus.func_ex == 6'h10);
  assign is_mthi  = is_r && (bus.func_ex == 6'h11);
  assign is_mflo  = is_r && (bus.func_ex == 6'h12);
  assign is_mtlo  = is_r && (bus.func_ex == 6'h13);

  assign busy_w  = (state_reg == BUSY);
  assign stall_w = bus.ex_valid && busy_w && (is_start || is_hilo);
  assign accept  = bus.ex_valid && !stall_w;

  // func bit 0 clear selects the signed variant (MULT 18, DIV 1A).
  assign start_signed = !bus.func_ex[0];
  assign rs_neg = start_signed && bus.rs_val[WIDTH-1];
  assign rt_neg = start_signed && bus.rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;

  // One iteration of the shift-add multiplier or the restoring divider.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_reg};
    acc_next  = acc_reg;
    if (is_mul_reg) begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end

    // Sign correction of the final step's result. A zero divisor leaves the dividend
    // magnitude in the remainder, so re-applying the dividend sign restores rs_val.
    prod_fix = res_neg_reg ? -acc_next : acc_next;
    quot_fix = dz_reg ? '1 :
               (res_neg_reg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0]);
    rem_fix  = rem_neg_reg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      is_mul_reg  <= 1'b0;
      res_neg_reg <= 1'b0;
      rem_neg_reg <= 1'b0;
      dz_reg      <= 1'b0;
      opb_reg     <= '0;
      acc_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && is_start) begin
            is_mul_reg  <= !bus.func_ex[1];
            res_neg_reg <= rs_neg ^ rt_neg;
            rem_neg_reg <= rs_neg;
            dz_reg      <= (bus.rt_val == '0);
            cnt_reg     <= '0;
            state_reg   <= BUSY;
            if (!bus.func_ex[1]) begin
              opb_reg <= rs_mag;
              acc_reg <= {{WIDTH{1'b0}}, rt_mag};
            end else begin
              opb_reg <= rt_mag;
              acc_reg <= {{WIDTH{1'b0}}, rs_mag};
            end
          end else if (accept && is_mthi) begin
            hi_reg <= bus.rs_val;
          end else if (accept && is_mtlo) begin
            lo_reg <= bus.rs_val;
          end
        end
        BUSY: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= IDLE;
            if (is_mul_reg) begin
              hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
              lo_reg <= prod_fix[WIDTH-1:0];
            end else begin
              hi_reg <= rem_fix;
              lo_reg <= quot_fix;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_w;
  assign bus.stall_req = stall_w;
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;
  assign bus.mf_data   = (accept && is_mfhi) ? hi_reg :
                         (accept && is_mflo) ? lo_reg : '0;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv. Directed scenarios and random operations
// are checked against a plain-arithmetic reference model (64-bit products, / and %).
module tb_ex_muldiv;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  ex_muldiv_if #(.WIDTH(W)) bus ();
  ex_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: results from the arithmetic definition of each instruction.
  function automatic logic [63:0] ref_mul(input logic [5:0] f, input logic [31:0] a, b);
    longint sa, sb;
    if (f == F_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Returns {hi, lo} = {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic [5:0] f, input logic [31:0] a, b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (f == F_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, b);
    if (f == F_MULT || f == F_MULTU) return ref_mul(f, a, b);
    return ref_div(f, a, b);
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.ex_valid  = v;
    bus.opcode_ex = op;
    bus.func_ex   = f;
    bus.rs_val    = a;
    bus.rt_val    = b;
  endtask

  // Issue one start instruction for a single cycle and count the busy cycles that follow.
  // Returns at the first idle cycle with results visible.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    drive(1'b1, 6'h00, f, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    #1;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    $display("op func=%02h rs=%08h rt=%08h -> hi=%08h lo=%08h busy_cycles=%0d",
             f, a, b, bus.hi, bus.lo, cyc);
  endtask

  // One-cycle HI/LO access instruction (no result returned).
  task automatic pulse(input logic v, input logic [5:0] op, input logic [5:0] f,
                       input logic [31:0] a);
    @(negedge clk);
    drive(v, op, f, a, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    #1;
    $display("hilo v=%0b op=%02h func=%02h rs=%08h -> hi=%08h lo=%08h", v, op, f, a, bus.hi, bus.lo);
  endtask

  task automatic test_reset();
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%08h exp=00000000", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%08h exp=00000000", bus.lo); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
    drive(1'b1, 6'h00, F_MFHI, 32'd0, 32'd0);
    #1;
    n_checks++; if (bus.mf_data !== 32'd0) begin n_fail++; $display("FAIL reset_mfhi got=%08h exp=00000000", bus.mf_data); end
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    $display("reset done");
  endtask

  task automatic check_op(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
    int cyc;
    logic [63:0] exp;
    exp = ref_op(f, a, b);
    run_op(f, a, b, cyc);
    n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL %s_cycles got=%0d exp=32", name, cyc); end
    n_checks++; if (bus.hi !== exp[63:32]) begin n_fail++; $display("FAIL %s_hi got=%08h exp=%08h", name, bus.hi, exp[63:32]); end
    n_checks++; if (bus.lo !== exp[31:0]) begin n_fail++; $display("FAIL %s_lo got=%08h exp=%08h", name, bus.lo, exp[31:0]); end
  endtask

  task automatic test_mult();
    check_op("mult_neg2x3", F_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    check_op("multu_neg2x3", F_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    check_op("mult_minxmin", F_MULT, 32'h8000_0000, 32'h8000_0000);
    check_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    check_op("div_neg7_2", F_DIV, 32'hFFFF_FFF9, 32'd2);
    check_op("divu_100_7", F_DIVU, 32'd100, 32'd7);
    check_op("divu_5_0", F_DIVU, 32'd5, 32'd0);
    check_op("div_neg5_0", F_DIV, 32'hFFFF_FFFB, 32'd0);
    check_op("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("div_7_neg2", F_DIV, 32'd7, 32'hFFFF_FFFE);
  endtask

  task automatic test_hilo_access();
    pulse(1'b1, 6'h00, F_MTHI, 32'h1234_5678);
    n_checks++; if (bus.hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi got=%08h exp=12345678", bus.hi); end
    pulse(1'b0, 6'h00, F_MTHI, 32'hCAFE_BABE);
    n_checks++; if (bus.hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_bubble got=%08h exp=12345678", bus.hi); end
    pulse(1'b1, 6'h00, F_MTLO, 32'h0BAD_F00D);
    n_checks++; if (bus.lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mtlo got=%08h exp=0badf00d", bus.lo); end
    pulse(1'b1, 6'h01, F_MTLO, 32'h1111_2222);
    n_checks++; if (bus.lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mtlo_badopc got=%08h exp=0badf00d", bus.lo); end
    @(negedge clk);
    drive(1'b1, 6'h00, F_MFHI, 32'd0, 32'd0);
    #1;
    n_checks++; if (bus.mf_data !== 32'h1234_5678) begin n_fail++; $display("FAIL mfhi got=%08h exp=12345678", bus.mf_data); end
    drive(1'b1, 6'h00, F_MFLO, 32'd0, 32'd0);
    #1;
    n_checks++; if (bus.mf_data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mflo got=%08h exp=0badf00d", bus.mf_data); end
    drive(1'b0, 6'h00, F_MFLO, 32'd0, 32'd0);
    #1;
    n_checks++; if (bus.mf_data !== 32'd0) begin n_fail++; $display("FAIL mflo_bubble got=%08h exp=00000000", bus.mf_data); end
    drive(1'b1, 6'h00, F_ADD, 32'd0, 32'd0);
    #1;
    n_checks++; if (bus.mf_data !== 32'd0) begin n_fail++; $display("FAIL mf_add got=%08h exp=00000000", bus.mf_data); end
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    $display("hi/lo access done");
  endtask

  // DIVU 100/7 in flight; ADD must not stall; MFLO presented before edge 5 stalls until done.
  task automatic test_stall();
    int e;
    int stalls;
    @(negedge clk);
    drive(1'b1, 6'h00, F_DIVU, 32'd100, 32'd7);
    @(posedge clk);                          // edge 0
    @(negedge clk);
    drive(1'b1, 6'h00, F_ADD, 32'd1, 32'd2);
    #1;
    n_checks++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL stall_add got=%b exp=0", bus.stall_req); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy got=%b exp=1", bus.busy); end
    e = 0;
    while (e < 4) begin @(posedge clk); e++; end
    @(negedge clk);
    drive(1'b1, 6'h00, F_MFLO, 32'd0, 32'd0);
    #1;
    stalls = 0;
    while (bus.stall_req && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    n_checks++; if (stalls !== 28) begin n_fail++; $display("FAIL stall_cycles got=%0d exp=28", stalls); end
    n_checks++; if (bus.mf_data !== 32'd14) begin n_fail++; $display("FAIL stall_mflo got=%08h exp=0000000e", bus.mf_data); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL stall_hi got=%08h exp=00000002", bus.hi); end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    $display("stall: mflo stalled %0d cycles, then read %08h", stalls, bus.mf_data);
  endtask

  // A start held while busy is accepted the cycle after completion.
  task automatic test_back_to_back();
    int n;
    logic [63:0] exp1, exp2;
    logic [31:0] a, b, c, d;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom_range(1, 1000);
    exp1 = ref_op(F_MULT, a, b);
    exp2 = ref_op(F_DIVU, c, d);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MULT, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 6'h00, F_DIVU, c, d);
    #1;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL b2b_first_cycles got=%0d exp=32", n); end
    n_checks++; if ({bus.hi, bus.lo} !== exp1) begin n_fail++; $display("FAIL b2b_first got=%016h exp=%016h", {bus.hi, bus.lo}, exp1); end
    n_checks++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL b2b_release got=%b exp=0", bus.stall_req); end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    #1;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL b2b_second_cycles got=%0d exp=32", n); end
    n_checks++; if ({bus.hi, bus.lo} !== exp2) begin n_fail++; $display("FAIL b2b_second got=%016h exp=%016h", {bus.hi, bus.lo}, exp2); end
    $display("back-to-back MULT %08h*%08h then DIVU %08h/%08h -> hi=%08h lo=%08h", a, b, c, d, bus.hi, bus.lo);
  endtask

  // Stalled MTHI and start requests that are flushed must leave no trace.
  task automatic test_flush();
    int n;
    logic [63:0] exp;
    exp = ref_op(F_MULTU, 32'd3, 32'd5);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MULTU, 32'd3, 32'd5);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 5) drive(1'b1, 6'h00, F_MTHI, 32'hDEAD_BEEF, 32'd0);
      else       drive(1'b1, 6'h00, F_DIVU, 32'd9, 32'd4);
      #1;
      n_checks++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL flush_stall%0d got=%b exp=1", i, bus.stall_req); end
    end
    @(negedge clk);
    drive(1'b0, 6'h00, F_DIVU, 32'd9, 32'd4);
    #1;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
    n_checks++; if ({bus.hi, bus.lo} !== exp) begin n_fail++; $display("FAIL flush_result got=%016h exp=%016h", {bus.hi, bus.lo}, exp); end
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    $display("flush: hi=%08h lo=%08h busy=%b", bus.hi, bus.lo, bus.busy);
  endtask

  task automatic test_random();
    logic [5:0] f;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      check_op("random", f, a, b);
    end
  endtask

  // Reset at edge 10 of a MULT aborts it; a fresh MULT still completes normally.
  task automatic test_reset_mid();
    pulse(1'b1, 6'h00, F_MTHI, 32'hAAAA_5555);
    pulse(1'b1, 6'h00, F_MTLO, 32'h5555_AAAA);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MULT, 32'h0001_2345, 32'hFFFF_0010);
    @(posedge clk);                          // edge 0
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    for (int e = 1; e < 10; e++) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(posedge clk);                          // edge 10
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi got=%08h exp=00000000", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_lo got=%08h exp=00000000", bus.lo); end
    $display("reset mid-op: busy=%b hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
    check_op("mult_after_rst", F_MULT, 32'h0001_2345, 32'hFFFF_0010);
  endtask

  initial begin
    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    test_reset();
    test_mult();
    test_div();
    test_hilo_access();
    test_stall();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
